// File: rtl/macrocell_cfg_loader.sv
// Serial configuration loader for macrocell.
// Bits are shifted into a shadow register. After the full frame arrives, the
// parity is checked. On a pass, the first 21 bits are committed atomically to
// the held mux selects, so macrocell never sees a half-loaded configuration.
module macrocell_cfg_loader #(
  parameter int FRAME_BITS = 22
) (
  input  logic       clk_v,
  input  logic       rstn_v,
  input  logic       cfg_start_v,
  input  logic       cfg_valid_v,
  input  logic       cfg_bit_v,
  output logic       pt1_mux,
  output logic       pt2_mux,
  output logic       pt3_mux,
  output logic       pt4_mux,
  output logic       pt5_mux,
  output logic       gclr_mux,
  output logic       pt4_func_mux,
  output logic       pt5_func_mux,
  output logic       xor_a_mux,
  output logic       xor_b_mux,
  output logic       xor_inv_mux,
  output logic       d_mux,
  output logic       dfast_mux,
  output logic       storage_mux,
  output logic       fb_mux,
  output logic       o_mux,
  output logic [0:2] oe_mux,
  output logic [0:1] gclk_mux,
  output logic       cfg_busy_v,
  output logic       cfg_done_v,
  output logic       cfg_err_v
);

  localparam int         CFG_BITS = FRAME_BITS - 1;
  localparam logic [4:0] LAST_IDX = 5'(FRAME_BITS - 1);

  typedef enum logic [1:0] {IDLE, SHIFT, CHECK} state_t;

  state_t                state_q, state_d;
  logic [4:0]            cnt_q, cnt_d;
  logic [FRAME_BITS-1:0] shadow_q, shadow_d;
  logic [CFG_BITS-1:0]   act_q, act_d;
  logic                  done_q, done_d;
  logic                  err_q, err_d;

  // State register and datapath flops, synchronous active-low reset
  always_ff @(posedge clk_v) begin
    if (!rstn_v) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      shadow_q <= '0;
      act_q    <= '0;
      done_q   <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      shadow_q <= shadow_d;
      act_q    <= act_d;
      done_q   <= done_d;
      err_q    <= err_d;
    end
  end

  // Next state: frame reception, parity check and atomic commit
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    shadow_d = shadow_q;
    act_d    = act_q;
    done_d   = 1'b0;
    err_d    = err_q;
    case (state_q)
      IDLE: begin
        // A valid bit that arrives together with start is not captured
        if (cfg_start_v) begin
          shadow_d = '0;
          cnt_d    = '0;
          err_d    = 1'b0;
          state_d  = SHIFT;
        end
      end
      SHIFT: begin
        if (cfg_start_v) begin
          // Restart: the bit in this cycle is dropped
          shadow_d = '0;
          cnt_d    = '0;
          err_d    = 1'b0;
        end else if (cfg_valid_v) begin
          shadow_d[cnt_q] = cfg_bit_v;
          if (cnt_q == LAST_IDX) begin
            cnt_d   = '0;
            state_d = CHECK;
          end else begin
            cnt_d = cnt_q + 5'd1;
          end
        end
      end
      CHECK: begin
        // Even parity over the whole frame, including the parity bit
        if (^shadow_q == 1'b0) begin
          act_d  = shadow_q[CFG_BITS-1:0];
          done_d = 1'b1;
        end else begin
          err_d = 1'b1;
        end
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Outputs: held selects in frame order, plus status flags
  always_comb begin
    pt1_mux      = act_q[0];
    pt2_mux      = act_q[1];
    pt3_mux      = act_q[2];
    pt4_mux      = act_q[3];
    pt5_mux      = act_q[4];
    gclr_mux     = act_q[5];
    pt4_func_mux = act_q[6];
    pt5_func_mux = act_q[7];
    xor_a_mux    = act_q[8];
    xor_b_mux    = act_q[9];
    xor_inv_mux  = act_q[10];
    d_mux        = act_q[11];
    dfast_mux    = act_q[12];
    storage_mux  = act_q[13];
    fb_mux       = act_q[14];
    o_mux        = act_q[15];
    oe_mux       = {act_q[16], act_q[17], act_q[18]};
    gclk_mux     = {act_q[19], act_q[20]};
    cfg_busy_v   = (state_q != IDLE);
    cfg_done_v   = done_q;
    cfg_err_v    = err_q;
  end

endmodule

// File: tb/tb_macrocell_cfg_loader.sv
// Directed bench for macrocell_cfg_loader. It checks reset, a good frame,
// bad parity, valid gaps, a mid-frame restart and a reset in mid-frame.
module tb_macrocell_cfg_loader;

  logic clk_v = 1'b0;
  logic rstn_v = 1'b0;
  logic cfg_start_v = 1'b0;
  logic cfg_valid_v = 1'b0;
  logic cfg_bit_v = 1'b0;
  logic pt1_mux, pt2_mux, pt3_mux, pt4_mux, pt5_mux, gclr_mux;
  logic pt4_func_mux, pt5_func_mux, xor_a_mux, xor_b_mux, xor_inv_mux;
  logic d_mux, dfast_mux, storage_mux, fb_mux, o_mux;
  logic [0:2] oe_mux;
  logic [0:1] gclk_mux;
  logic cfg_busy_v, cfg_done_v, cfg_err_v;

  int checks = 0;
  int failures = 0;
  int done_cnt = 0;
  int busy_cnt = 0;

  // Frame bits 0,15,16,18,19 set; parity bit 21 set to make the frame even
  localparam logic [21:0] GOOD     = 22'h2D8001;
  localparam logic [21:0] BAD      = 22'h0D8001;
  localparam logic [20:0] GOOD_CFG = 21'h0D8001;
  localparam logic [21:0] ONES     = 22'h3FFFFF;

  // Held selects regathered into frame order (bit i = frame index i)
  logic [20:0] obs;
  assign obs = {gclk_mux[1], gclk_mux[0], oe_mux[2], oe_mux[1], oe_mux[0],
                o_mux, fb_mux, storage_mux, dfast_mux, d_mux, xor_inv_mux,
                xor_b_mux, xor_a_mux, pt5_func_mux, pt4_func_mux, gclr_mux,
                pt5_mux, pt4_mux, pt3_mux, pt2_mux, pt1_mux};

  macrocell_cfg_loader #(.FRAME_BITS(22)) dut (
    .clk_v(clk_v), .rstn_v(rstn_v), .cfg_start_v(cfg_start_v),
    .cfg_valid_v(cfg_valid_v), .cfg_bit_v(cfg_bit_v),
    .pt1_mux(pt1_mux), .pt2_mux(pt2_mux), .pt3_mux(pt3_mux),
    .pt4_mux(pt4_mux), .pt5_mux(pt5_mux), .gclr_mux(gclr_mux),
    .pt4_func_mux(pt4_func_mux), .pt5_func_mux(pt5_func_mux),
    .xor_a_mux(xor_a_mux), .xor_b_mux(xor_b_mux), .xor_inv_mux(xor_inv_mux),
    .d_mux(d_mux), .dfast_mux(dfast_mux), .storage_mux(storage_mux),
    .fb_mux(fb_mux), .o_mux(o_mux), .oe_mux(oe_mux), .gclk_mux(gclk_mux),
    .cfg_busy_v(cfg_busy_v), .cfg_done_v(cfg_done_v), .cfg_err_v(cfg_err_v)
  );

  always #5 clk_v = ~clk_v;

  task automatic tick();
    @(posedge clk_v);
    #1;
    if (cfg_done_v === 1'b1) done_cnt++;
    if (cfg_busy_v === 1'b1) busy_cnt++;
  endtask

  task automatic chk(input string tag, input logic [31:0] o, input logic [31:0] e);
    checks++;
    assert (o === e) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, o, e);
    end
  endtask

  // Send the first n bits of f back to back, or with a 3-cycle valid gap after every 5th bit
  task automatic send(input logic [21:0] f, input int n, input bit gaps);
    for (int i = 0; i < n; i++) begin
      cfg_valid_v = 1'b1;
      cfg_bit_v   = f[i];
      tick();
      if (gaps && ((i + 1) % 5 == 0) && (i != n - 1)) begin
        cfg_valid_v = 1'b0;
        cfg_bit_v   = 1'b1;
        repeat (3) tick();
      end
    end
    cfg_valid_v = 1'b0;
    cfg_bit_v   = 1'b0;
  endtask

  initial begin
    // Reset
    rstn_v = 1'b0;
    repeat (2) tick();
    chk("rst_cfg", 32'(obs), 32'h0);
    chk("rst_busy", 32'(cfg_busy_v), 32'h0);
    chk("rst_done", 32'(cfg_done_v), 32'h0);
    chk("rst_err", 32'(cfg_err_v), 32'h0);
    rstn_v = 1'b1;
    tick();

    // Good frame
    busy_cnt = 0; done_cnt = 0;
    cfg_start_v = 1'b1; tick(); cfg_start_v = 1'b0;
    chk("good_busy_start", 32'(cfg_busy_v), 32'h1);
    send(GOOD, 22, 1'b0);
    chk("good_check_busy", 32'(cfg_busy_v), 32'h1);
    chk("good_check_nodone", 32'(cfg_done_v), 32'h0);
    chk("good_check_hold", 32'(obs), 32'h0);
    tick();
    chk("good_done", 32'(cfg_done_v), 32'h1);
    chk("good_busy_low", 32'(cfg_busy_v), 32'h0);
    chk("good_cfg", 32'(obs), 32'(GOOD_CFG));
    chk("good_oe", 32'(oe_mux), 32'h5);
    chk("good_gclk", 32'(gclk_mux), 32'h2);
    chk("good_pt1", 32'(pt1_mux), 32'h1);
    chk("good_o", 32'(o_mux), 32'h1);
    chk("good_err", 32'(cfg_err_v), 32'h0);
    tick();
    chk("good_done_clr", 32'(cfg_done_v), 32'h0);
    chk("good_busy_cycles", 32'(busy_cnt), 32'd23);
    chk("good_done_cycles", 32'(done_cnt), 32'd1);

    // Bad parity
    done_cnt = 0;
    cfg_start_v = 1'b1; tick(); cfg_start_v = 1'b0;
    send(BAD, 22, 1'b0);
    tick();
    chk("bad_err", 32'(cfg_err_v), 32'h1);
    chk("bad_busy", 32'(cfg_busy_v), 32'h0);
    chk("bad_cfg_hold", 32'(obs), 32'(GOOD_CFG));
    chk("bad_no_done", 32'(done_cnt), 32'd0);
    // Start right after CHECK, with a valid bit that must be ignored
    busy_cnt = 0; done_cnt = 0;
    cfg_start_v = 1'b1; cfg_valid_v = 1'b1; cfg_bit_v = 1'b1;
    tick();
    cfg_start_v = 1'b0; cfg_valid_v = 1'b0; cfg_bit_v = 1'b0;
    chk("bad_err_clr", 32'(cfg_err_v), 32'h0);
    chk("bad_restart_busy", 32'(cfg_busy_v), 32'h1);
    chk("bad_err_clr_hold", 32'(obs), 32'(GOOD_CFG));

    // Valid gaps, all-zero frame
    send(22'h0, 22, 1'b1);
    chk("gap_check_busy", 32'(cfg_busy_v), 32'h1);
    chk("gap_check_hold", 32'(obs), 32'(GOOD_CFG));
    chk("gap_check_nodone", 32'(cfg_done_v), 32'h0);
    tick();
    chk("gap_done", 32'(cfg_done_v), 32'h1);
    chk("gap_cfg", 32'(obs), 32'h0);
    chk("gap_err", 32'(cfg_err_v), 32'h0);
    chk("gap_busy_cycles", 32'(busy_cnt), 32'd35);
    tick();

    // Mid-frame restart
    done_cnt = 0;
    cfg_start_v = 1'b1; tick(); cfg_start_v = 1'b0;
    send(ONES, 10, 1'b0);
    cfg_start_v = 1'b1; cfg_valid_v = 1'b1; cfg_bit_v = 1'b1;
    tick();
    cfg_start_v = 1'b0; cfg_valid_v = 1'b0; cfg_bit_v = 1'b0;
    chk("rs_busy", 32'(cfg_busy_v), 32'h1);
    send(GOOD, 22, 1'b0);
    chk("rs_check_nodone", 32'(done_cnt), 32'd0);
    chk("rs_check_busy", 32'(cfg_busy_v), 32'h1);
    tick();
    chk("rs_done", 32'(cfg_done_v), 32'h1);
    chk("rs_cfg", 32'(obs), 32'(GOOD_CFG));
    chk("rs_err", 32'(cfg_err_v), 32'h0);
    tick();

    // Reset mid-frame
    cfg_start_v = 1'b1; tick(); cfg_start_v = 1'b0;
    send(ONES, 15, 1'b0);
    rstn_v = 1'b0; tick(); rstn_v = 1'b1;
    chk("mrst_cfg", 32'(obs), 32'h0);
    chk("mrst_busy", 32'(cfg_busy_v), 32'h0);
    chk("mrst_done", 32'(cfg_done_v), 32'h0);
    chk("mrst_err", 32'(cfg_err_v), 32'h0);
    done_cnt = 0; busy_cnt = 0;
    send(GOOD, 22, 1'b0);
    repeat (3) tick();
    chk("mrst_nostart_cfg", 32'(obs), 32'h0);
    chk("mrst_nostart_busy", 32'(busy_cnt), 32'd0);
    chk("mrst_nostart_done", 32'(done_cnt), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
